// File: rtl/isqrt_rr_share_pkg.sv
// Shared constants and helpers for the round-robin isqrt sharing block.
package isqrt_rr_share_pkg;

  localparam int unsigned ISQRT_IN_W  = 32;
  localparam int unsigned ISQRT_OUT_W = 16;

  // Round-robin pointer increment with wrap to zero.
  function automatic int unsigned rr_next(int unsigned ptr, int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/isqrt.sv
// Pipelined integer square root, restoring digit-by-digit; latency n_pipe_stages cycles.
module isqrt
  import isqrt_rr_share_pkg::*;
#(
  parameter int unsigned n_pipe_stages = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   x_vld_i,
  input  logic [ISQRT_IN_W-1:0]  x_i,
  output logic                   y_vld_o,
  output logic [ISQRT_OUT_W-1:0] y_o
);

  localparam int unsigned Iters = ISQRT_OUT_W;
  localparam int unsigned Ips   = (Iters + n_pipe_stages - 1) / n_pipe_stages;
  localparam int unsigned RemW  = ISQRT_OUT_W + 4;

  for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
    logic                   vld_q, in_vld;
    logic [RemW-1:0]        rem_q, rem_in, rem_out;
    logic [ISQRT_OUT_W-1:0] root_q, root_in, root_out;
    logic [ISQRT_IN_W-1:0]  xs_q, xs_in, xs_out;

    if (s == 0) begin : g_first
      assign in_vld  = x_vld_i;
      assign rem_in  = '0;
      assign root_in = '0;
      assign xs_in   = x_i;
    end else begin : g_next
      assign in_vld  = g_stage[s-1].vld_q;
      assign rem_in  = g_stage[s-1].rem_q;
      assign root_in = g_stage[s-1].root_q;
      assign xs_in   = g_stage[s-1].xs_q;
    end

    // Each iteration pulls two operand bits into the remainder and decides one root bit.
    always_comb begin
      rem_out  = rem_in;
      root_out = root_in;
      xs_out   = xs_in;
      for (int unsigned j = 0; j < Ips; j++) begin
        if (s * Ips + j < Iters) begin
          rem_out = {rem_out[RemW-3:0], xs_out[ISQRT_IN_W-1 -: 2]};
          xs_out  = {xs_out[ISQRT_IN_W-3:0], 2'b00};
          if (rem_out >= {2'b00, root_out, 2'b01}) begin
            rem_out  = rem_out - {2'b00, root_out, 2'b01};
            root_out = {root_out[ISQRT_OUT_W-2:0], 1'b1};
          end else begin
            root_out = {root_out[ISQRT_OUT_W-2:0], 1'b0};
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= in_vld;
      end
    end

    always_ff @(posedge clk_i) begin
      if (in_vld) begin
        rem_q  <= rem_out;
        root_q <= root_out;
        xs_q   <= xs_out;
      end
    end
  end

  assign y_vld_o = g_stage[n_pipe_stages-1].vld_q;
  assign y_o     = g_stage[n_pipe_stages-1].root_q;

  logic unused_tail;
  assign unused_tail = ^{g_stage[n_pipe_stages-1].rem_q, g_stage[n_pipe_stages-1].xs_q};

endmodule

// File: rtl/isqrt_rr_share_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] gnt_id_o,
  output logic           gnt_any_o
);

  logic [IdW:0]   sum;
  logic [IdW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_any_o = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IdW + 1)'(k);
      if (sum >= (IdW + 1)'(N)) begin
        sum = sum - (IdW + 1)'(N);
      end
      idx = sum[IdW-1:0];
      if (!gnt_any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
        gnt_any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/isqrt_rr_share.sv
// Round-robin sharing of one pipelined isqrt among N_REQ requesters, with an ID tag pipeline.
module isqrt_rr_share
  import isqrt_rr_share_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned N_PIPE_STAGES = 4,
  localparam int unsigned ID_W         = $clog2(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_vld_i,
  input  logic [N_REQ*ISQRT_IN_W-1:0] req_x_i,
  output logic [N_REQ-1:0]            req_rdy_o,
  output logic                        res_vld_o,
  output logic [ID_W-1:0]             res_id_o,
  output logic [ISQRT_OUT_W-1:0]      res_y_o,
  output logic                        busy_o
);

  logic [N_REQ-1:0]       gnt;
  logic [ID_W-1:0]        gnt_id;
  logic                   gnt_any;
  logic                   transfer;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ISQRT_IN_W-1:0]  x_q, x_d;
  logic                   y_vld;
  logic [ISQRT_OUT_W-1:0] y;
  logic [N_PIPE_STAGES-1:0] tag_vld_q;
  logic [ID_W-1:0]        tag_id_q [N_PIPE_STAGES];
  logic [ISQRT_IN_W-1:0]  req_x_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_x_arr[i] = req_x_i[ISQRT_IN_W*i +: ISQRT_IN_W];
  end

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .req_i    (req_vld_i),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .gnt_any_o(gnt_any)
  );

  assign transfer  = gnt_any & ~rst_i;
  assign req_rdy_o = rst_i ? '0 : gnt;

  // Operand bus holds its last value when idle to avoid needless toggling.
  assign x_d   = transfer ? req_x_arr[gnt_id] : x_q;
  assign ptr_d = transfer ? ID_W'(rr_next(32'(gnt_id), N_REQ)) : ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (transfer) begin
      x_q <= x_d;
    end
  end

  isqrt #(
    .n_pipe_stages(N_PIPE_STAGES)
  ) u_isqrt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .x_vld_i(transfer),
    .x_i    (x_d),
    .y_vld_o(y_vld),
    .y_o    (y)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= transfer;
      for (int unsigned s = 1; s < N_PIPE_STAGES; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (transfer) begin
      tag_id_q[0] <= gnt_id;
    end
    for (int unsigned s = 1; s < N_PIPE_STAGES; s++) begin
      if (tag_vld_q[s-1]) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  assign res_vld_o = y_vld;
  assign res_id_o  = tag_vld_q[N_PIPE_STAGES-1] ? tag_id_q[N_PIPE_STAGES-1] : '0;
  assign res_y_o   = y_vld ? y : '0;
  assign busy_o    = (|tag_vld_q) | transfer;

endmodule
